cos_sweep_ctrl: RTL and testbench
=================================

Name: cos_sweep_ctrl

Overview:
- Initiator-side controller for the Horner cosine unit (start / ready_out / angle_in / cos_out handshake).
- Steps an angle from a programmed first value to a last value, issues one cosine request per point, and captures each {angle, cos} result into an internal result buffer.
- A host drains the buffer through a simple read port.
- Sits between a host register block and the cosine datapath; replaces bench-style stimulus in silicon.

Parameters:
- WIDTH, 24, fixed-point word width (angle and cos), 10 fractional bits.
- DEPTH, 16, result buffer entries (power of two).
- TIMEOUT, 255, max cycles waiting for cos_ready per request.

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- go  in  1  one-cycle sweep start request; ignored while busy.
- angle_first  in  WIDTH  first angle, unsigned; sampled on accepted go.
- angle_step  in  WIDTH  increment, unsigned; sampled on accepted go.
- angle_last  in  WIDTH  inclusive upper bound, unsigned; sampled on accepted go.
- busy  out  1  sweep in progress.
- done  out  1  one-cycle pulse when the sweep ends.
- error  out  1  sticky timeout flag; cleared by the next accepted go.
- count  out  $clog2(DEPTH)+1  number of results stored.
- cos_start  out  1  request pulse to the cosine unit.
- cos_angle  out  WIDTH  angle presented to the cosine unit.
- cos_ready  in  1  cosine unit ready/level; completion is its 0->1 edge.
- cos_value  in  WIDTH  cosine result; valid on the cos_ready rising edge.
- rd_en  in  1  read request, pop one entry.
- rd_valid  out  1  rd_angle/rd_cos valid (one cycle).
- rd_angle  out  WIDTH  read-back angle.
- rd_cos  out  WIDTH  read-back cosine.

Behaviour:
- Reset (reset=0, async): state=IDLE. All outputs 0, count=0, buffer pointers 0, cos_ready edge register 0.
- FSM states: IDLE, ISSUE, WAIT, STORE, NEXT, FIN.
- IDLE: accepting go
  - Latches first/step/last and sets the current angle to first.
  - Clears count, the write/read pointers and error.
  - Sets busy=1 and moves to ISSUE.
- ISSUE: drives cos_angle=current and cos_start=1 for exactly one cycle, then moves to WAIT.
  - cos_angle holds its value until the next ISSUE.
- WAIT: timer increments each cycle.
  - On the cos_ready rising edge (registered previous value 0, current 1): go to STORE.
  - On timer==TIMEOUT: set error=1 and go to FIN, storing nothing.
  - A cos_ready that is already high on entry is not a completion.
- STORE: writes {current, cos_value captured on the edge cycle} at the write pointer and increments count.
  - If count reaches DEPTH: go to FIN.
  - Otherwise: go to NEXT.
- NEXT: computes sum = current + step as WIDTH+1 bits.
  - If step==0, sum carries out, or sum > last: go to FIN.
  - Otherwise current=sum[WIDTH-1:0] and go to ISSUE.
- first > last: exactly one point (first) is still computed.
- FIN: done=1 for one cycle, busy=0, then IDLE. Buffer contents are retained.
- Per-point latency: 1 (ISSUE) + unit latency + 1 (edge detect) + 1 (STORE) + 1 (NEXT).
- Read port:
  - rd_en is honoured only when busy=0 and read pointer < count.
  - rd_valid, rd_angle and rd_cos are registered and appear one cycle after rd_en; the read pointer then increments.
  - rd_en in any other case is ignored (rd_valid=0).
  - Reads never alter count.
- go while busy: ignored, no effect on parameters or state.
- go and rd_en in the same cycle in IDLE: go wins, buffer is cleared, the read is dropped.
- Reset mid-sweep returns to IDLE immediately. The cosine unit is not notified; its late cos_ready is ignored because the edge register is reset.

Decomposition:
- Shared package cos_fxp_pkg:
  - WIDTH=24 and FRAC=10 constants.
  - typedef fxp_t (logic [23:0]).
  - typedef result_t (struct {fxp_t angle; fxp_t cos;}).
  - FSM state enum.
- One natural sub-module, cos_result_buf: DEPTH x result_t register array with write port, registered read port and pointers. The FSM stays in the top.

Test Plan:
- Behavioural cosine model with 8-cycle latency. first=0, step=102, last=1434 -> 15 requests with angles 0,102,...,1428; count=15; done pulses once; error=0; rd_angle sequence matches; rd_cos matches the model.
- step=0, first=512 -> exactly one request; count=1; rd_angle=512.
- first=0, step=1, last=100 -> stops at buffer full; count=16; last rd_angle=15; error=0.
- Model never raises cos_ready, TIMEOUT=255 -> error=1; done 257 cycles after cos_start; count=0; rd_en produces no rd_valid.
- first=0xFFFF00, step=0x80, last=0xFFFFFF -> angles 0xFFFF00, 0xFFFF80, then carry stop; count=2.
- Reset driven low during the 3rd WAIT, late cos_ready after release -> busy=0, count=0, no spurious STORE; a new go runs cleanly. go pulsed while busy -> sampled parameters unchanged.

Source files
------------

// File: rtl/cos_fxp_pkg.sv
// rtl/cos_fxp_pkg.sv - fixed-point types, result record and sweep FSM states
package cos_fxp_pkg;

  localparam int WIDTH = 24;
  localparam int FRAC  = 10;

  typedef logic [WIDTH-1:0] fxp_t;

  typedef struct packed {
    fxp_t angle;
    fxp_t cos;
  } result_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_STORE,
    ST_NEXT,
    ST_FIN
  } sweep_state_t;

  // One extra bit so that the sweep can see the angle wrapping past full scale.
  function automatic logic [WIDTH:0] fxp_add_wide(fxp_t a, fxp_t b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/cos_sweep_ctrl_if.sv
// rtl/cos_sweep_ctrl_if.sv - request/response handshake to the cosine unit
interface cos_sweep_ctrl_if;
  import cos_fxp_pkg::*;

  logic cos_start;
  fxp_t cos_angle;
  logic cos_ready;
  fxp_t cos_value;

  modport master (
    output cos_start,
    output cos_angle,
    input  cos_ready,
    input  cos_value
  );

  modport slave (
    input  cos_start,
    input  cos_angle,
    output cos_ready,
    output cos_value
  );

endinterface

// File: rtl/cos_result_buf.sv
// rtl/cos_result_buf.sv - result store with write count, read pointer and registered read
module cos_result_buf
  import cos_fxp_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clr,
  input  logic          wr_en,
  input  result_t       wr_data,
  input  logic          rd_en,
  output logic          rd_valid,
  output result_t       rd_data,
  output logic [CW-1:0] count
);

  result_t       mem [DEPTH];
  logic [CW-1:0] rd_ptr;
  logic          wr_ok;
  logic          rd_ok;

  assign wr_ok = wr_en && (count < CW'(DEPTH));
  assign rd_ok = rd_en && (rd_ptr < count);

  // Storage array; contents survive reset and sweep end so the host can drain later.
  always_ff @(posedge clock) begin
    if (wr_ok) begin
      mem[count[AW-1:0]] <= wr_data;
    end
  end

  // Write count doubles as the write pointer; read pointer never passes it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count  <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      count  <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok) begin
        count <= count + 1'b1;
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Registered read data, valid for one cycle after an honoured request.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_ok;
      if (rd_ok) begin
        rd_data <= mem[rd_ptr[AW-1:0]];
      end
    end
  end

endmodule

// File: rtl/cos_sweep_ctrl.sv
// rtl/cos_sweep_ctrl.sv - angle sweep sequencer driving the cosine unit and buffering results
module cos_sweep_ctrl
  import cos_fxp_pkg::*;
#(
  parameter  int DEPTH   = 16,
  parameter  int TIMEOUT = 255,
  localparam int CW      = $clog2(DEPTH) + 1,
  localparam int TW      = $clog2(TIMEOUT + 1)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    go,
  input  fxp_t                    angle_first,
  input  fxp_t                    angle_step,
  input  fxp_t                    angle_last,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic [CW-1:0]           count,
  cos_sweep_ctrl_if.master        cos,
  input  logic                    rd_en,
  output logic                    rd_valid,
  output fxp_t                    rd_angle,
  output fxp_t                    rd_cos
);

  sweep_state_t     state;
  sweep_state_t     state_nxt;

  fxp_t             cur;
  fxp_t             step_q;
  fxp_t             last_q;
  fxp_t             cap_cos;
  logic             rdy_q;
  logic [TW-1:0]    timer;

  logic             go_acc;
  logic             rdy_edge;
  logic             timed_out;
  logic [WIDTH:0]   sum;
  logic             stop;
  logic             full_next;

  logic             wr_en;
  logic             buf_clr;
  logic             rd_req;
  result_t          rd_data;

  assign go_acc    = (state == ST_IDLE) && go;
  assign rdy_edge  = cos.cos_ready && !rdy_q;
  assign timed_out = (timer == TW'(TIMEOUT));
  assign sum       = fxp_add_wide(cur, step_q);
  assign stop      = (step_q == '0) || (sum > {1'b0, last_q});
  assign full_next = (count == CW'(DEPTH - 1));

  // The current angle only changes on the way into ISSUE, so it serves as cos_angle directly.
  assign cos.cos_angle = cur;
  assign rd_angle      = rd_data.angle;
  assign rd_cos        = rd_data.cos;

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; a completion edge takes priority over a same-cycle timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (go) state_nxt = ST_ISSUE;
      ST_ISSUE: state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (rdy_edge) begin
          state_nxt = ST_STORE;
        end else if (timed_out) begin
          state_nxt = ST_FIN;
        end
      end
      ST_STORE: state_nxt = full_next ? ST_FIN : ST_NEXT;
      ST_NEXT:  state_nxt = stop ? ST_FIN : ST_ISSUE;
      ST_FIN:   state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Moore outputs plus the buffer strobes; go beats a simultaneous read in IDLE.
  always_comb begin
    busy          = 1'b0;
    done          = 1'b0;
    cos.cos_start = 1'b0;
    wr_en         = 1'b0;
    buf_clr       = go_acc;
    rd_req        = 1'b0;
    case (state)
      ST_IDLE:  rd_req = rd_en && !go_acc;
      ST_ISSUE: begin
        busy          = 1'b1;
        cos.cos_start = 1'b1;
      end
      ST_WAIT:  busy = 1'b1;
      ST_STORE: begin
        busy  = 1'b1;
        wr_en = 1'b1;
      end
      ST_NEXT:  busy = 1'b1;
      ST_FIN: begin
        done   = 1'b1;
        rd_req = rd_en;
      end
      default: ;
    endcase
  end

  // Sweep parameters, current angle, wait timer, captured result and sticky error.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cur     <= '0;
      step_q  <= '0;
      last_q  <= '0;
      cap_cos <= '0;
      timer   <= '0;
      error   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (go) begin
            cur    <= angle_first;
            step_q <= angle_step;
            last_q <= angle_last;
            error  <= 1'b0;
          end
        end
        ST_ISSUE: timer <= '0;
        ST_WAIT: begin
          timer <= timer + 1'b1;
          if (rdy_edge) begin
            cap_cos <= cos.cos_value;
          end else if (timed_out) begin
            error <= 1'b1;
          end
        end
        ST_NEXT: begin
          if (!stop) begin
            cur <= sum[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  // Previous cos_ready level; clearing it on reset hides a late completion from an abandoned request.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rdy_q <= 1'b0;
    end else begin
      rdy_q <= cos.cos_ready;
    end
  end

  cos_result_buf #(
    .DEPTH (DEPTH)
  ) u_buf (
    .clock    (clock),
    .reset    (reset),
    .clr      (buf_clr),
    .wr_en    (wr_en),
    .wr_data  (result_t'{angle: cur, cos: cap_cos}),
    .rd_en    (rd_req),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .count    (count)
  );

endmodule

// File: tb/tb_cos_sweep_ctrl.sv
// tb/tb_cos_sweep_ctrl.sv - scoreboard bench for cos_sweep_ctrl with a behavioural cosine unit
module tb_cos_sweep_ctrl;
  import cos_fxp_pkg::*;

  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          go    = 1'b0;
  logic          rd_en = 1'b0;
  fxp_t          angle_first = '0;
  fxp_t          angle_step  = '0;
  fxp_t          angle_last  = '0;
  logic          busy;
  logic          done;
  logic          error;
  logic [CW-1:0] count;
  logic          rd_valid;
  fxp_t          rd_angle;
  fxp_t          rd_cos;

  cos_sweep_ctrl_if cif ();

  cos_sweep_ctrl #(
    .DEPTH   (DEPTH),
    .TIMEOUT (255)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .go          (go),
    .angle_first (angle_first),
    .angle_step  (angle_step),
    .angle_last  (angle_last),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .count       (count),
    .cos         (cif.master),
    .rd_en       (rd_en),
    .rd_valid    (rd_valid),
    .rd_angle    (rd_angle),
    .rd_cos      (rd_cos)
  );

  always #5 clock = ~clock;

  int      total = 0;
  int      bad   = 0;
  int      cyc   = 0;
  int      done_cnt = 0;
  int      req_cnt  = 0;
  int      rd_cnt   = 0;
  int      start_cyc = 0;
  int      done_cyc  = 0;
  int      model_mode = 0;
  fxp_t    last_rd_angle = '0;
  fxp_t    exp_req_q [$];
  result_t exp_rd_q  [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic fxp_t cos_ref(input fxp_t a);
    real s;
    real r;
    s = real'(1 << FRAC);
    r = $cos(real'(a) / s) * s;
    return fxp_t'($rtoi(r));
  endfunction

  // Cosine unit: drops ready on a request, raises it with the result 8 cycles later,
  // then scrambles the value so a late capture is visible.
  initial begin
    cif.cos_ready = 1'b0;
    cif.cos_value = '0;
    forever begin
      fxp_t a;
      @(negedge clock);
      if (cif.cos_start) begin
        a = cif.cos_angle;
        cif.cos_ready = 1'b0;
        cif.cos_value = 24'hBADBAD;
        if (model_mode == 0) begin
          repeat (8) @(negedge clock);
          cif.cos_value = cos_ref(a);
          cif.cos_ready = 1'b1;
          @(negedge clock);
          cif.cos_value = ~cos_ref(a);
        end
      end
    end
  end

  // Output monitor: pops the scoreboard on every request and every read response.
  initial begin
    forever begin
      @(negedge clock);
      cyc++;
      if (cif.cos_start) begin
        req_cnt++;
        start_cyc = cyc;
        check("req_expected", 32'(exp_req_q.size() > 0), 32'd1);
        if (exp_req_q.size() > 0) begin
          check("req_angle", 32'(cif.cos_angle), 32'(exp_req_q.pop_front()));
        end
      end
      if (rd_valid) begin
        result_t e;
        rd_cnt++;
        last_rd_angle = rd_angle;
        check("rd_expected", 32'(exp_rd_q.size() > 0), 32'd1);
        if (exp_rd_q.size() > 0) begin
          e = exp_rd_q.pop_front();
          check("rd_angle", 32'(rd_angle), 32'(e.angle));
          check("rd_cos", 32'(rd_cos), 32'(e.cos));
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic push_sweep(input fxp_t f, input fxp_t s, input fxp_t l, input int mode);
    logic [WIDTH:0] sum;
    fxp_t           a;
    result_t        r;
    int             n;
    a = f;
    n = 0;
    while (1) begin
      exp_req_q.push_back(a);
      if (mode == 0) begin
        r.angle = a;
        r.cos   = cos_ref(a);
        exp_rd_q.push_back(r);
      end
      n++;
      if (mode != 0 || n == DEPTH) break;
      sum = {1'b0, a} + {1'b0, s};
      if (s == '0 || sum > {1'b0, l}) break;
      a = sum[WIDTH-1:0];
    end
  endtask

  task automatic pulse_go(input fxp_t f, input fxp_t s, input fxp_t l);
    angle_first = f;
    angle_step  = s;
    angle_last  = l;
    go = 1'b1;
    @(negedge clock);
    go = 1'b0;
  endtask

  task automatic sweep(input string tag, input fxp_t f, input fxp_t s, input fxp_t l,
                       input int mode, input bit noise);
    int d0;
    int i;
    d0 = done_cnt;
    model_mode = mode;
    push_sweep(f, s, l, mode);
    pulse_go(f, s, l);
    i = 0;
    while (done_cnt == d0 && i < 1200) begin
      if (noise && i == 20) begin
        pulse_go(24'd0, 24'd1, 24'd3);
      end else begin
        @(negedge clock);
      end
      i++;
    end
    repeat (5) @(negedge clock);
    check({tag, "_done_once"}, 32'(done_cnt - d0), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_req_left"}, 32'(exp_req_q.size()), 32'd0);
  endtask

  task automatic drain(input string tag, input int extra);
    int r0;
    int n;
    r0 = rd_cnt;
    n  = int'(count) + extra;
    for (int k = 0; k < n; k++) begin
      rd_en = 1'b1;
      @(negedge clock);
    end
    rd_en = 1'b0;
    repeat (2) @(negedge clock);
    check({tag, "_rd_left"}, 32'(exp_rd_q.size()), 32'd0);
    check({tag, "_rd_cnt"}, 32'(rd_cnt - r0), 32'(n - extra));
  endtask

  initial begin
    int r0;
    int d0;
    int i;

    repeat (3) @(negedge clock);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_start", 32'(cif.cos_start), 32'd0);
    check("rst_angle", 32'(cif.cos_angle), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    sweep("basic", 24'd0, 24'd102, 24'd1434, 0, 1'b0);
    check("basic_count", 32'(count), 32'd15);
    check("basic_error", 32'(error), 32'd0);
    drain("basic", 2);
    check("basic_last_rd", 32'(last_rd_angle), 32'd1428);
    check("basic_count_kept", 32'(count), 32'd15);

    sweep("tmo", 24'd100, 24'd10, 24'd200, 1, 1'b0);
    check("tmo_error", 32'(error), 32'd1);
    check("tmo_latency", 32'(done_cyc - start_cyc), 32'd257);
    check("tmo_count", 32'(count), 32'd0);
    drain("tmo", 2);

    sweep("step0", 24'd512, 24'd0, 24'd4000, 0, 1'b0);
    check("step0_count", 32'(count), 32'd1);
    check("step0_error", 32'(error), 32'd0);
    drain("step0", 1);
    check("step0_rd", 32'(last_rd_angle), 32'd512);

    sweep("full", 24'd0, 24'd1, 24'd100, 0, 1'b0);
    check("full_count", 32'(count), 32'd16);
    check("full_error", 32'(error), 32'd0);
    drain("full", 2);
    check("full_last_rd", 32'(last_rd_angle), 32'd15);

    sweep("carry", 24'hFFFF00, 24'h80, 24'hFFFFFF, 0, 1'b0);
    check("carry_count", 32'(count), 32'd2);
    drain("carry", 1);
    check("carry_last_rd", 32'(last_rd_angle), 32'hFFFF80);

    sweep("rev", 24'd900, 24'd5, 24'd300, 0, 1'b0);
    check("rev_count", 32'(count), 32'd1);
    drain("rev", 1);

    model_mode = 0;
    r0 = req_cnt;
    d0 = done_cnt;
    push_sweep(24'd0, 24'd100, 24'd1000, 0);
    pulse_go(24'd0, 24'd100, 24'd1000);
    i = 0;
    while (req_cnt < r0 + 3 && i < 200) begin
      @(negedge clock);
      i++;
    end
    check("rst_mid_reached", 32'(req_cnt - r0), 32'd3);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    exp_req_q.delete();
    exp_rd_q.delete();
    repeat (20) @(negedge clock);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_count", 32'(count), 32'd0);
    check("rst_mid_reqs", 32'(req_cnt - r0), 32'd3);
    check("rst_mid_done", 32'(done_cnt - d0), 32'd0);

    sweep("noise", 24'd200, 24'd50, 24'd500, 0, 1'b1);
    check("noise_count", 32'(count), 32'd7);
    check("noise_error", 32'(error), 32'd0);
    drain("noise", 1);
    check("noise_last_rd", 32'(last_rd_angle), 32'd500);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
